// File: rtl/a10_xcvr_reconfig_arbiter.sv
// Round-robin arbiter sharing one Arria 10 reconfig Avalon-MM port between NREQ requesters.
// Optional slave-stall timeout enabled by defining A10_XCVR_RECONFIG_ARB_TIMEOUT_EN.
module a10_xcvr_reconfig_arbiter #(
  parameter int NREQ    = 2,
  parameter int AWIDTH  = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ*AWIDTH-1:0] req_address,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*32-1:0]     req_writedata,
  input  logic [NREQ-1:0]        req_read,
  input  logic [NREQ-1:0]        req_lock,
  output logic [31:0]            req_readdata,
  output logic [NREQ-1:0]        req_waitrequest,
  output logic [NREQ-1:0]        grant,
  output logic [AWIDTH-1:0]      avm_address,
  output logic                   avm_write,
  output logic [31:0]            avm_writedata,
  output logic                   avm_read,
  input  logic [31:0]            avm_readdata,
  input  logic                   avm_waitrequest,
  output logic                   timeout_err
);

  // state    | meaning
  // ST_IDLE  | no owner; pick next pending requester round-robin
  // ST_OWNED | owner_q drives the shared port until release
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_OWNED = 1'b1;
  localparam int   IW       = $clog2(NREQ);

  logic          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic [NREQ-1:0] pend;
  logic          owned, own_pend, own_lock, own_rd, own_wr;
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic          force_done;
  logic          release_own;

  assign pend     = req_read | req_write;
  assign owned    = (state_q == ST_OWNED);
  assign own_pend = pend[owner_q];
  assign own_lock = req_lock[owner_q];
  assign own_rd   = req_read[owner_q];
  assign own_wr   = req_write[owner_q];
  assign grant    = grant_q;

  // Scan starts just past the last owner so nobody wins twice while others wait.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && pend[IW'(idx)]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end

  always_comb begin
    avm_address     = '0;
    avm_writedata   = '0;
    avm_write       = 1'b0;
    avm_read        = 1'b0;
    req_waitrequest = '1;
    if (owned) begin
      avm_address   = req_address[owner_q*AWIDTH +: AWIDTH];
      avm_writedata = req_writedata[owner_q*32 +: 32];
      avm_write     = own_wr;
      avm_read      = own_rd & ~own_wr;
      req_waitrequest[owner_q] = avm_waitrequest & ~force_done;
    end
  end

  assign req_readdata = force_done ? 32'hDEAD_BEEF : avm_readdata;
  assign release_own  = force_done | (~own_lock & (~own_pend | ~avm_waitrequest));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    if (!owned) begin
      if (win_found) begin
        state_d          = ST_OWNED;
        owner_d          = win_idx;
        grant_d          = '0;
        grant_d[win_idx] = 1'b1;
      end
    end else if (release_own) begin
      state_d = ST_IDLE;
      grant_d = '0;
      last_d  = owner_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

`ifdef A10_XCVR_RECONFIG_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          terr_q, terr_d;
  logic          stalled;

  assign stalled     = owned & own_pend & avm_waitrequest;
  // Fires on the TIMEOUT-th consecutive stalled cycle.
  assign force_done  = stalled & (cnt_q == CW'(TIMEOUT - 1));
  assign cnt_d       = (stalled & ~force_done) ? cnt_q + 1'b1 : '0;
  assign terr_d      = terr_q | force_done;
  assign timeout_err = terr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      terr_q <= terr_d;
    end
  end
`else
  localparam int TIMEOUT_UNUSED = TIMEOUT;

  assign force_done  = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
